// File: rtl/decoder_pkg.sv
// Shared definitions for the sequenced one-hot decoder.
// Holds the sweep-controller state type used by decoder_seq_n.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_seq_n_decoder.sv
// Decoder_N: combinational binary-to-one-hot decoder.
// Ports:
//   code : N-bit binary input
//   o    : 2**N-bit one-hot output, bit[code] set
module Decoder_N #(
  parameter int N = 4
) (
  input  logic [N-1:0]    code,
  output logic [2**N-1:0] o
);

  always_comb begin
    o       = '0;
    o[code] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq_n.sv
// decoder_seq_n: one-hot decoder with a single-entry valid/ready output
// stage and an automatic sweep mode that emits every code 0..M-1 once.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake for code
//   code                : N-bit binary code
//   sweep_start         : request a sweep (honoured in IDLE only)
//   out_valid/out_ready : output handshake for o
//   o                   : M-bit one-hot decode
//   sweep_busy          : high while sweeping
//   sweep_done          : one-cycle pulse after the last sweep code is loaded
module decoder_seq_n
  import decoder_pkg::*;
#(
  parameter int N     = 4,
  parameter bit PULSE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    code,
  input  logic            sweep_start,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] o,
  output logic            sweep_busy,
  output logic            sweep_done
);

  localparam int M = 2**N;
  localparam logic [N-1:0] LAST = '1;

  state_t         state, state_nxt;
  logic [N-1:0]   cnt, cnt_nxt;
  logic [N-1:0]   dec_code;
  logic [M-1:0]   oh, o_q;
  logic           room, sweep_ld, load;

  // Output stage can take a new entry when empty or draining this cycle.
  assign room     = !out_valid || out_ready;
  // Sweep request wins over a simultaneous code; nothing is accepted in reset.
  assign in_ready = (state == IDLE) && !sweep_start && room && !rst;
  assign sweep_ld = (state == SWEEP) && room;
  assign load     = (in_valid && in_ready) || sweep_ld;
  assign dec_code = (state == SWEEP) ? cnt : code;

  Decoder_N #(.N(N)) u_dec (
    .code (dec_code),
    .o    (oh)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (sweep_start) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        if (sweep_ld) begin
          // Leave after the last code so the counter never starts a second pass.
          if (cnt == LAST) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      o_q       <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        out_valid <= 1'b1;
        o_q       <= oh;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign sweep_busy = (state == SWEEP);
  assign sweep_done = (state == DONE);
  assign o          = (PULSE && !out_valid) ? '0 : o_q;

endmodule

// File: tb/tb_decoder_seq_n.sv
module tb_decoder_seq_n;
  localparam int N = 4;
  localparam int M = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, sweep_start = 1'b0, out_ready = 1'b0;
  logic [N-1:0] code = '0;
  logic in_ready, out_valid, sweep_busy, sweep_done;
  logic in_ready1, out_valid1, sweep_busy1, sweep_done1;
  logic [M-1:0] o0, o1;

  decoder_seq_n #(.N(N), .PULSE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code(code),
    .sweep_start(sweep_start), .out_valid(out_valid), .out_ready(out_ready),
    .o(o0), .sweep_busy(sweep_busy), .sweep_done(sweep_done));

  decoder_seq_n #(.N(N), .PULSE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .code(code),
    .sweep_start(sweep_start), .out_valid(out_valid1), .out_ready(out_ready),
    .o(o1), .sweep_busy(sweep_busy1), .sweep_done(sweep_done1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 sweeping, 2 done
  int m_st = 0, m_idx = 0, m_code = 0;
  bit m_ov = 0, m_have = 0;
  int dlog[$];

  function automatic bit m_rdy();
    return !rst && m_st == 0 && !sweep_start && (!m_ov || out_ready);
  endfunction

  function automatic logic [M-1:0] e_o(input bit pulse);
    logic [M-1:0] v;
    v = '0;
    if (m_have && !(pulse && !m_ov)) v[m_code] = 1'b1;
    return v;
  endfunction

  function automatic int oh_idx(input logic [M-1:0] v);
    for (int i = 0; i < M; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drv(input bit iv, input logic [N-1:0] c, input bit ss, input bit ordy);
    in_valid = iv; code = c; sweep_start = ss; out_ready = ordy;
    #1;
  endtask

  // Advance model and DUT one clock; logs delivered codes as observed.
  task automatic tick();
    bit ld; int lc;
    if (out_valid && out_ready) dlog.push_back(oh_idx(o0));
    ld = 0; lc = 0;
    if (rst) begin
      m_st = 0; m_idx = 0; m_ov = 0; m_have = 0;
    end else begin
      case (m_st)
        0: begin
          if (in_valid && m_rdy()) begin ld = 1; lc = int'(code); end
          if (sweep_start) begin m_st = 1; m_idx = 0; end
        end
        1: begin
          if (!m_ov || out_ready) begin
            ld = 1; lc = m_idx;
            if (m_idx == M-1) m_st = 2;
            m_idx++;
          end
        end
        default: m_st = 0;
      endcase
      if (ld) begin m_ov = 1; m_code = lc; m_have = 1; end
      else if (out_ready) m_ov = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv(1'b1, N'($urandom), 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    tick(); tick();
    rst = 1'b0;
    drv(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if ({out_valid, sweep_busy, sweep_done} !== 3'b000) begin
      errors++; $display("FAIL rst_ctl: got ov/busy/done=%b want 000", {out_valid, sweep_busy, sweep_done});
    end
    checks++;
    if (o0 !== '0 || o1 !== '0) begin errors++; $display("FAIL rst_o: got %h/%h want 0/0", o0, o1); end
  endtask

  task automatic test_direct();
    drv(1'b1, 4'h5, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL direct_ready: got %b want 1", in_ready); end
    tick();
    drv(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || o0 !== 16'h0020 || o1 !== 16'h0020) begin
      errors++; $display("FAIL direct_out: got ov=%b o=%h/%h want 1 0020/0020", out_valid, o0, o1);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || o0 !== 16'h0020 || o1 !== 16'h0000) begin
      errors++; $display("FAIL direct_after: got ov=%b o=%h/%h want 0 0020/0000", out_valid, o0, o1);
    end
  endtask

  task automatic test_backpressure();
    int n3;
    dlog.delete();
    drv(1'b1, 4'h3, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", in_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 4'h9, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || o0 !== 16'h0008 || o1 !== 16'h0008) begin
        errors++; $display("FAIL bp_stall%0d: got rdy=%b ov=%b o=%h want 0 1 0008", k, in_ready, out_valid, o0);
      end
      tick();
    end
    drv(1'b1, 4'h9, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    drv(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || o0 !== 16'h0200) begin
      errors++; $display("FAIL bp_next: got ov=%b o=%h want 1 0200", out_valid, o0);
    end
    n3 = 0;
    foreach (dlog[i]) if (dlog[i] == 3) n3++;
    checks++;
    if (n3 != 1 || dlog.size() != 1) begin
      errors++; $display("FAIL bp_single: got %0d transfers of 3 (%0d total) want 1 (1)", n3, dlog.size());
    end
    tick();
    drv(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_sweep();
    int beats, busy, dones, first, last;
    logic [M-1:0] exp;
    beats = 0; busy = 0; dones = 0; first = -1; last = -1;
    drv(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL sweep_start_ready: got %b want 0", in_ready); end
    tick();
    for (int c = 0; c < 40; c++) begin
      drv(1'b0, '0, 1'b0, 1'b1);
      if (sweep_busy) busy++;
      if (sweep_done) dones++;
      if (out_valid) begin
        exp = '0;
        if (beats < M) exp[beats] = 1'b1;
        checks++;
        if (o0 !== exp || o1 !== exp) begin
          errors++; $display("FAIL sweep_beat%0d: got %h/%h want %h", beats, o0, o1, exp);
        end
        if (first < 0) first = c;
        last = c;
        beats++;
      end
      tick();
    end
    checks++;
    if (beats != 16 || last - first != 15) begin
      errors++; $display("FAIL sweep_beats: got %0d beats span %0d want 16 span 15", beats, last - first);
    end
    checks++;
    if (busy != 16) begin errors++; $display("FAIL sweep_busy: got %0d cycles want 16", busy); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL sweep_done: got %0d pulses want 1", dones); end
  endtask

  task automatic test_sweep_toggle();
    bit fin;
    fin = 0;
    dlog.delete();
    drv(1'b0, '0, 1'b1, 1'b1);
    tick();
    for (int c = 0; c < 100 && !fin; c++) begin
      drv(1'b0, '0, 1'b0, c[0]);
      checks++;
      if ({out_valid, sweep_busy, sweep_done} !== {m_ov, m_st == 1, m_st == 2} || o0 !== e_o(0) || o1 !== e_o(1)) begin
        errors++; $display("FAIL toggle_cyc%0d: got ov/busy/done=%b o=%h want %b o=%h",
                           c, {out_valid, sweep_busy, sweep_done}, o0, {m_ov, m_st == 1, m_st == 2}, e_o(0));
      end
      tick();
      if (c > 2 && m_st == 0 && !m_ov) fin = 1;
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL toggle_timeout: got unfinished want finished within 100"); end
    checks++;
    if (dlog.size() != 16) begin errors++; $display("FAIL toggle_count: got %0d want 16", dlog.size()); end
    foreach (dlog[i]) begin
      checks++;
      if (dlog[i] != i) begin errors++; $display("FAIL toggle_order%0d: got %0d want %0d", i, dlog[i], i); end
    end
  endtask

  task automatic test_collision();
    bit seen;
    seen = 0;
    drv(1'b1, 4'hA, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL coll_ready: got %b want 0", in_ready); end
    tick();
    for (int c = 0; c < 5 && !seen; c++) begin
      drv(1'b0, '0, 1'b0, 1'b1);
      if (out_valid) begin
        seen = 1;
        checks++;
        if (o0 !== 16'h0001) begin errors++; $display("FAIL coll_first: got %h want 0001", o0); end
      end
      tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL coll_timeout: got no output want output within 5"); end
    for (int c = 0; c < 40; c++) begin drv(1'b0, '0, 1'b0, 1'b1); tick(); end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    drv(1'b0, '0, 1'b1, 1'b1);
    tick();
    drv(1'b0, '0, 1'b0, 1'b1);
    repeat (7) tick();
    rst = 1'b1;
    drv(1'b1, 4'h2, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    drv(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if ({out_valid, sweep_busy, sweep_done} !== 3'b000 || o0 !== '0 || o1 !== '0) begin
      errors++; $display("FAIL midrst_state: got ov/busy/done=%b o=%h want 000 o=0", {out_valid, sweep_busy, sweep_done}, o0);
    end
    for (int c = 0; c < 20; c++) begin
      drv(1'b0, '0, 1'b0, 1'b1);
      if (sweep_done || out_valid || sweep_busy) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles want 0", dones); end
  endtask

  task automatic test_random();
    logic [3:0] e_ctl;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drv(1'($urandom), N'($urandom), $urandom_range(0, 19) == 0, ($urandom % 4) != 0);
      e_ctl = {m_rdy(), m_ov, m_st == 1, m_st == 2};
      checks++;
      if ({in_ready, out_valid, sweep_busy, sweep_done} !== e_ctl ||
          {in_ready1, out_valid1, sweep_busy1, sweep_done1} !== e_ctl) begin
        errors++;
        if (errors < 20) $display("FAIL rand_ctl%0d: got %b/%b want %b", c,
          {in_ready, out_valid, sweep_busy, sweep_done}, {in_ready1, out_valid1, sweep_busy1, sweep_done1}, e_ctl);
      end
      checks++;
      if (o0 !== e_o(0) || o1 !== e_o(1) || $countones(o0) > 1 || $countones(o1) > 1) begin
        errors++;
        if (errors < 20) $display("FAIL rand_o%0d: got %h/%h want %h/%h", c, o0, o1, e_o(0), e_o(1));
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_backpressure();
    test_sweep();
    test_sweep_toggle();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_seq_n.md
DECODER_SEQ_N -- requirements
Module: decoder_seq_n

Interface
REQ-001 SHALL have parameter N, default 4: code width in bits.
REQ-002 SHALL have parameter PULSE, default 0: 0 = output holds last one-hot, 1 = output nonzero only while out_valid.
REQ-003 SHALL derive localparam M = 2**N (output width); N SHALL be 1..8.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  code presented.
REQ-007 in_ready  output  1  block accepts code this cycle.
REQ-008 code  input  N  binary code to decode.
REQ-009 sweep_start  input  1  request automatic sweep of codes 0..M-1.
REQ-010 out_valid  output  1  o holds an undelivered decode.
REQ-011 out_ready  input  1  consumer takes o this cycle.
REQ-012 o  output  M  one-hot decode, bit[code] set.
REQ-013 sweep_busy  output  1  high in SWEEP state.
REQ-014 sweep_done  output  1  one-cycle pulse on sweep completion.

Function
REQ-015 SHALL hold a single-entry registered output stage; decode latency 1 cycle from acceptance to out_valid.
REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 in_ready SHALL equal (state==IDLE) && !sweep_start && (!out_valid || out_ready).
REQ-018 Simultaneous output transfer and new load SHALL replace the entry with no bubble (full throughput).
REQ-019 out_valid SHALL clear after output transfer when no new load occurs the same cycle.
REQ-020 Output entry SHALL be stable while out_valid && !out_ready.
REQ-021 FSM states: IDLE, SWEEP, DONE.
REQ-022 IDLE -> SWEEP when sweep_start=1; sweep_start SHALL be ignored in SWEEP and DONE.
REQ-023 sweep_start and in_valid both high in IDLE: sweep wins; code not accepted (in_ready=0).
REQ-024 In SWEEP, N-bit counter cnt (cleared to 0 on entry) SHALL load code cnt into the output stage whenever (!out_valid || out_ready), then increment.
REQ-025 Loading cnt = M-1 SHALL move SWEEP -> DONE; counter SHALL NOT wrap into a second pass.
REQ-026 DONE SHALL last exactly one cycle with sweep_done=1, then -> IDLE; last sweep entry may still be pending on output.
REQ-027 sweep_busy SHALL be 1 exactly while state==SWEEP.
REQ-028 PULSE=0: o SHALL retain last loaded one-hot after out_valid falls; PULSE=1: o SHALL be all-zero whenever out_valid=0.
REQ-029 o SHALL always have at most one bit set.

Reset
REQ-030 rst=1 SHALL force state=IDLE, cnt=0, out_valid=0, o=0, sweep_done=0, sweep_busy=0 on the next edge, overriding all other inputs.
REQ-031 Reset mid-sweep SHALL abort the sweep without sweep_done and discard the pending entry.
REQ-032 in_ready SHALL be 0 during any cycle rst=1.

Structure
REQ-033 Shared package decoder_pkg SHALL hold the FSM state enum typedef (IDLE, SWEEP, DONE).
REQ-034 Combinational binary-to-one-hot SHALL reuse existing Decoder_N instantiated with N; total RTL 120-400 lines.

Verification (N=4, M=16)
REQ-035 Direct: code=4'h5 accepted, out_ready=1 -> next cycle out_valid=1, o=16'h0020, then out_valid=0.
REQ-036 Backpressure: accept 4'h3, out_ready=0 for 3 cycles -> o=16'h0008 stable, in_ready=0; release -> single transfer, then accept 4'h9 -> o=16'h0200.
REQ-037 Sweep: pulse sweep_start, out_ready=1 -> 16 consecutive beats o=16'h0001..16'h8000, sweep_busy high 16 cycles, one sweep_done pulse.
REQ-038 Sweep with out_ready toggling 1/0 -> each of 16 codes delivered exactly once, in order, none duplicated.
REQ-039 Collision: sweep_start=1 with in_valid=1, code=4'hA in IDLE -> code not accepted, first output o=16'h0001.
REQ-040 Reset after 7 sweep beats -> out_valid=0, o=0, state IDLE, no sweep_done; PULSE=1 run of REQ-035 -> o=0 the cycle after transfer.
